// File: rtl/hamming_frame_sequencer_pkg.sv
// Shared definitions for the Hamming frame sequencer.
// DATA_BITS : nibble width streamed into the serial coder.
// CW_BITS   : codeword width collected from the serial coder.
// hseq_state_t : sequencer FSM states, also exported for observation.
package hamming_pkg;

  localparam int DATA_BITS = 4;
  localparam int CW_BITS   = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } hseq_state_t;

endpackage

// File: rtl/hamming_frame_sequencer_if.sv
// Bus bundle between the frame sequencer, its nibble sources, the codeword
// sink and the shared serial coder.
// Ports (all signals live in the interface):
//   req_valid/req_data/req_ready : per-requester nibble handshake
//   cw_valid/cw_data/cw_src/cw_ready : codeword result handshake
//   coder_reset/coder_enable/coder_in/coder_out : serial coder control/data
//   busy, fsm_state : sequencer status
// Handshake rule for both req_* and cw_*: a transfer happens on a rising
// clock edge where valid and ready are both high; the producer holds valid
// and its data stable until that edge, and ready may depend on valid.
// master = sequencer side, slave = environment side.
interface hamming_frame_sequencer_if #(
  parameter int NUM_REQ = 4
);
  import hamming_pkg::*;

  localparam int SW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]           req_valid;
  logic [DATA_BITS*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         cw_valid;
  logic [CW_BITS-1:0]           cw_data;
  logic [SW-1:0]                cw_src;
  logic                         cw_ready;
  logic                         coder_reset;
  logic                         coder_enable;
  logic                         coder_in;
  logic                         coder_out;
  logic                         busy;
  hseq_state_t                  fsm_state;

  modport master (
    input  req_valid, req_data, cw_ready, coder_out,
    output req_ready, cw_valid, cw_data, cw_src,
           coder_reset, coder_enable, coder_in, busy, fsm_state
  );

  modport slave (
    output req_valid, req_data, cw_ready, coder_out,
    input  req_ready, cw_valid, cw_data, cw_src,
           coder_reset, coder_enable, coder_in, busy, fsm_state
  );

endinterface

// File: rtl/hamming_frame_sequencer_rr_arbiter.sv
// Round-robin arbiter with an internal last-grant pointer.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset (pointer -> N-1)
//   req          : request vector
//   update       : load pointer with grant_idx (pulse when grant is taken)
//   grant        : one-hot grant, first request after the pointer
//   grant_idx    : binary index of the granted request
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [N-1:0]  req,
  input  logic          update,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] ptr;

  // Pointer starts at N-1 so requester 0 has priority after reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr <= IW'(N - 1);
    end else if (update) begin
      ptr <= grant_idx;
    end
  end

  // Scan ptr+1 .. ptr+N; the first active request wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (req[IW'(idx)] && (grant == '0)) begin
        grant[IW'(idx)] = 1'b1;
        grant_idx       = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/hamming_frame_sequencer.sv
// Shares one bit-serial Hamming [7,4] coder among NUM_REQ nibble producers.
// Each granted nibble is framed as: one clear cycle, RUN_CYCLES enabled
// cycles streaming the nibble LSB-first (then zeros), capturing 7 coder
// output bits starting at run index CAPTURE_START, then the codeword is
// offered on the cw_* port until accepted.
// Ports:
//   clk     : clock, rising edge
//   reset_n : synchronous active-low reset; drops any frame in flight
//   bus     : hamming_frame_sequencer_if.master (request, codeword, coder,
//             busy and fsm_state signals)
module hamming_frame_sequencer
  import hamming_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int RUN_CYCLES    = 11,
  parameter int CAPTURE_START = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  hamming_frame_sequencer_if.master   bus
);

  localparam int SW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int JW  = $clog2(RUN_CYCLES + 1);
  localparam int DIW = $clog2(DATA_BITS);
  localparam int CIW = $clog2(CW_BITS);

  hseq_state_t          state, state_next;
  logic [JW-1:0]        run_idx;
  logic [DATA_BITS-1:0] nibble, sel_nibble;
  logic [NUM_REQ-1:0]   grant;
  logic [SW-1:0]        grant_idx;
  logic                 handshake;
  logic                 reset_seen;
  logic                 capture;
  logic [CIW-1:0]       cap_idx;
  logic [CW_BITS-1:0]   cw_data;
  logic [SW-1:0]        cw_src;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (bus.req_valid),
    .update    (handshake),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Grants are only offered in IDLE and never while reset is asserted.
  assign handshake = (state == IDLE) && reset_n && (|grant);

  always_comb begin
    sel_nibble = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) sel_nibble = bus.req_data[DATA_BITS*i +: DATA_BITS];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (handshake) state_next = CLEAR;
      CLEAR:   state_next = RUN;
      RUN:     if (run_idx == JW'(RUN_CYCLES - 1)) state_next = DONE;
      DONE:    if (bus.cw_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Run index j: bit j of the capture window lands in cw_data[j-CAPTURE_START].
  assign capture = (state == RUN) &&
                   (run_idx >= JW'(CAPTURE_START)) &&
                   (run_idx <  JW'(CAPTURE_START + CW_BITS));
  assign cap_idx = CIW'(run_idx - JW'(CAPTURE_START));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      run_idx    <= '0;
      nibble     <= '0;
      cw_src     <= '0;
      cw_data    <= '0;
      reset_seen <= 1'b1;
    end else begin
      reset_seen <= 1'b0;
      if (handshake) begin
        nibble <= sel_nibble;
        cw_src <= grant_idx;
      end
      if (state == RUN) run_idx <= run_idx + 1'b1;
      else              run_idx <= '0;
      if (capture) cw_data[cap_idx] <= bus.coder_out;
    end
  end

  assign bus.req_ready    = handshake ? grant : '0;
  assign bus.cw_valid     = (state == DONE);
  assign bus.cw_data      = cw_data;
  assign bus.cw_src       = cw_src;
  // Coder is held clear in the cycle after reset as well as in CLEAR.
  assign bus.coder_reset  = (state == CLEAR) || reset_seen;
  assign bus.coder_enable = (state == RUN);
  assign bus.coder_in     = ((state == RUN) && (run_idx < JW'(DATA_BITS))) ?
                            nibble[run_idx[DIW-1:0]] : 1'b0;
  assign bus.busy         = (state != IDLE);
  assign bus.fsm_state    = state;

endmodule

// File: tb/tb_hamming_frame_sequencer.sv
module tb_hamming_frame_sequencer;
  import hamming_pkg::*;

  localparam int NUM_REQ       = 4;
  localparam int RUN_CYCLES    = 11;
  localparam int CAPTURE_START = 4;
  localparam int STUB_DELAY    = 4;
  localparam int SW            = 2;
  localparam int W             = SW + CW_BITS;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  hamming_frame_sequencer_if #(.NUM_REQ(NUM_REQ)) bus ();

  hamming_frame_sequencer #(
    .NUM_REQ(NUM_REQ), .RUN_CYCLES(RUN_CYCLES), .CAPTURE_START(CAPTURE_START)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Coder stub: output is the input delayed by STUB_DELAY enabled cycles.
  logic [STUB_DELAY-1:0] stub_sr;
  always @(posedge clk) begin
    if (bus.coder_reset)       stub_sr <= '0;
    else if (bus.coder_enable) stub_sr <= {stub_sr[STUB_DELAY-2:0], bus.coder_in};
  end
  assign bus.coder_out = stub_sr[STUB_DELAY-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int ptr);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int i;
      i = (ptr + k) % NUM_REQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Capture bit k is coder_out at run index CAPTURE_START+k, which is the
  // coder_in bit fed STUB_DELAY enabled cycles earlier.
  function automatic logic [CW_BITS-1:0] exp_cw(input logic [3:0] nib);
    logic [CW_BITS-1:0] r;
    r = '0;
    for (int k = 0; k < CW_BITS; k++) begin
      int s;
      s = CAPTURE_START + k - STUB_DELAY;
      if (s >= 0 && s < DATA_BITS) r[k] = (nib >> s) & 4'd1;
    end
    return r;
  endfunction

  logic [W-1:0]       exp_q[$];
  int                 m_phase = 0;   // 0 idle, 1 clear+run, 2 offering codeword
  int                 m_ptr = NUM_REQ - 1;
  int                 m_cnt = 0;
  int                 m_post_rst = 0;
  int                 m_frames = 0;
  int                 m_idx;
  int                 m_j;
  logic [3:0]         m_nib;
  logic [NUM_REQ-1:0] m_rdy;

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("ready_in_reset", bus.req_ready, 0);
      m_phase = 0; m_ptr = NUM_REQ - 1; m_cnt = 0; m_post_rst = 1;
      exp_q.delete();
    end else begin
      chk("busy", bus.busy, (m_phase != 0));
      chk("coder_reset", bus.coder_reset, (m_post_rst != 0) || (m_phase == 1 && m_cnt == 0));
      m_post_rst = 0;
      case (m_phase)
        0: begin
          m_idx = rr_pick(bus.req_valid, m_ptr);
          m_rdy = '0;
          if (m_idx >= 0) m_rdy[m_idx] = 1'b1;
          chk("req_ready", bus.req_ready, m_rdy);
          chk("idle_cw_valid", bus.cw_valid, 0);
          chk("idle_enable", bus.coder_enable, 0);
          if (m_idx >= 0) begin
            m_nib = bus.req_data[4*m_idx +: 4];
            exp_q.push_back({SW'(m_idx), exp_cw(m_nib)});
            m_ptr = m_idx; m_phase = 1; m_cnt = 0;
          end
        end
        1: begin
          chk("busy_ready", bus.req_ready, 0);
          chk("busy_cw_valid", bus.cw_valid, 0);
          if (m_cnt == 0) begin
            chk("clear_enable", bus.coder_enable, 0);
          end else begin
            chk("run_enable", bus.coder_enable, 1);
            m_j = m_cnt - 1;
            chk("coder_in", bus.coder_in, (m_j < DATA_BITS) ? int'((m_nib >> m_j) & 4'd1) : 0);
          end
          m_cnt++;
          if (m_cnt == RUN_CYCLES + 1) m_phase = 2;
        end
        default: begin
          chk("done_valid", bus.cw_valid, 1);
          chk("done_ready", bus.req_ready, 0);
          chk("done_enable", bus.coder_enable, 0);
          chk("done_frame", {bus.cw_src, bus.cw_data}, exp_q[0]);
          if (bus.cw_ready) begin
            void'(exp_q.pop_front());
            m_phase = 0;
            m_frames++;
          end
        end
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.cw_ready = 1'b1;
    repeat (2) tick();
    reset_n = 1'b1;
  endtask

  task automatic wait_hs(input int src, output int at);
    at = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.req_valid[src] && bus.req_ready[src]) begin
        at = cyc;
        break;
      end
    end
    chk("hs_in_time", (at >= 0), 1);
    tick();
  endtask

  task automatic wait_cw(output logic [CW_BITS-1:0] d, output int s, output int at);
    at = -1; d = '0; s = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.cw_valid) begin
        at = cyc; d = bus.cw_data; s = int'(bus.cw_src);
        break;
      end
    end
    chk("cw_in_time", (at >= 0), 1);
  endtask

  task automatic run_single(input int src, input logic [3:0] nib,
                            output logic [CW_BITS-1:0] d, output int s,
                            output int hs, output int at);
    tick();
    bus.req_data[4*src +: 4] = nib;
    bus.req_valid[src] = 1'b1;
    wait_hs(src, hs);
    bus.req_valid[src] = 1'b0;
    wait_cw(d, s, at);
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    int                 src;
    logic [3:0]         nib;
    logic [CW_BITS-1:0] cw;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [CW_BITS-1:0] d;
    int s, hs, at, prev_at;
    int ord_src[5];
    logic [CW_BITS-1:0] ord_cw[5];
    int tp_at[4];

    vecs[0] = '{0, 4'b1011, 7'b0001011};
    vecs[1] = '{1, 4'b0000, 7'b0000000};
    vecs[2] = '{2, 4'b1111, 7'b0001111};
    vecs[3] = '{3, 4'b0110, 7'b0000110};
    vecs[4] = '{1, 4'b1001, 7'b0001001};
    vecs[5] = '{0, 4'b0001, 7'b0000001};
    ord_src = '{0, 1, 2, 3, 0};
    ord_cw  = '{7'h01, 7'h02, 7'h03, 7'h04, 7'h01};

    bus.req_valid = '0;
    bus.req_data = '0;
    bus.cw_ready = 1'b1;
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_cw_valid", bus.cw_valid, 0);
    chk("rst_cw_data", bus.cw_data, 0);
    chk("rst_cw_src", bus.cw_src, 0);
    chk("rst_coder_reset", bus.coder_reset, 1);
    chk("rst_coder_enable", bus.coder_enable, 0);
    chk("rst_coder_in", bus.coder_in, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_state", bus.fsm_state, IDLE);
    @(negedge clk);
    chk("rst_coder_reset_drops", bus.coder_reset, 0);

    // Table-driven single frames
    for (int i = 0; i < 6; i++) begin
      run_single(vecs[i].src, vecs[i].nib, d, s, hs, at);
      chk("tbl_cw_data", d, vecs[i].cw);
      chk("tbl_cw_src", s, vecs[i].src);
      chk("tbl_latency", at - hs, RUN_CYCLES + 2);
      @(negedge clk);
      chk("tbl_one_cycle", bus.cw_valid, 0);
    end

    // All requesters valid: round-robin order
    do_reset();
    bus.req_data = {4'h4, 4'h3, 4'h2, 4'h1};
    bus.req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      wait_cw(d, s, at);
      chk("rr_src", s, ord_src[k]);
      chk("rr_cw", d, ord_cw[k]);
    end
    tick();
    bus.req_valid = '0;

    // req2 alone right after req3, then wrap to req0 after req3
    do_reset();
    run_single(3, 4'h5, d, s, hs, prev_at);
    chk("r3_src", s, 3);
    run_single(2, 4'h9, d, s, hs, at);
    chk("r2_immediate", hs, prev_at + 1);
    chk("r2_src", s, 2);
    chk("r2_cw", d, 7'b0001001);
    run_single(3, 4'hA, d, s, hs, prev_at);
    chk("r3b_src", s, 3);
    run_single(0, 4'h7, d, s, hs, at);
    chk("wrap_immediate", hs, prev_at + 1);
    chk("wrap_src", s, 0);
    chk("wrap_cw", d, 7'b0000111);

    // Backpressure in DONE
    do_reset();
    bus.cw_ready = 1'b0;
    bus.req_data[3:0] = 4'b1010;
    bus.req_data[7:4] = 4'h3;
    bus.req_valid = 4'b0011;
    wait_hs(0, hs);
    bus.req_valid[0] = 1'b0;
    wait_cw(d, s, at);
    chk("bp_cw", d, 7'b0001010);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      chk("bp_hold_valid", bus.cw_valid, 1);
      chk("bp_hold_data", bus.cw_data, 7'b0001010);
      chk("bp_no_grant", bus.req_ready, 0);
    end
    tick();
    bus.cw_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", bus.cw_valid, 1);
    @(negedge clk);
    chk("bp_idle_busy", bus.busy, 0);
    chk("bp_next_grant", bus.req_ready, 4'b0010);
    tick();
    bus.req_valid[1] = 1'b0;
    wait_cw(d, s, at);
    chk("bp_next_src", s, 1);
    chk("bp_next_cw", d, 7'b0000011);

    // Reset in the middle of RUN (j=5)
    tick();
    bus.req_data[3:0] = 4'b1101;
    bus.req_valid = 4'b0001;
    wait_hs(0, hs);
    bus.req_valid = '0;
    repeat (6) tick();
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_run_enable", bus.coder_enable, 1);
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    chk("mid_busy", bus.busy, 0);
    chk("mid_cw_valid", bus.cw_valid, 0);
    chk("mid_coder_reset", bus.coder_reset, 1);
    chk("mid_state", bus.fsm_state, IDLE);
    run_single(0, 4'b0110, d, s, hs, at);
    chk("mid_fresh_cw", d, 7'b0000110);
    chk("mid_fresh_src", s, 0);

    // Throughput with req1 continuously valid
    do_reset();
    bus.req_data[7:4] = 4'b1001;
    bus.req_valid = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      wait_cw(d, s, tp_at[k]);
      chk("tp_cw", d, 7'b0001001);
      if (k > 0) chk("tp_period", tp_at[k] - tp_at[k-1], RUN_CYCLES + 3);
    end
    tick();
    bus.req_valid = '0;

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      bus.req_valid = NUM_REQ'($urandom_range(0, 15));
      bus.req_data = 16'($urandom());
      bus.cw_ready = ($urandom_range(0, 3) != 0);
      reset_n = ($urandom_range(0, 199) != 0);
      tick();
    end
    reset_n = 1'b1;
    bus.req_valid = '0;
    bus.cw_ready = 1'b1;
    repeat (40) tick();
    chk("drain_queue", exp_q.size(), 0);
    chk("frames_seen", (m_frames > 20), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
